reaction_timer: RTL and testbench

Millisecond timing engine that responds to the timer commands (`reset`, `up`, `enable`) issued by the reaction-game FSM. It returns the 11-bit `timer_value` the FSM compares against, and runs the game-length seconds counter that produces `game_timer_value`. It sits between the board clock and the game FSM, replacing ad-hoc counters with one block that has defined saturation and terminal-count behaviour.

---
 rtl/reaction_game_pkg.sv | 21 ++
 rtl/ms_tick_gen.sv | 53 +++++
 rtl/reaction_timer.sv | 144 ++++++++++++++
 tb/tb_reaction_timer.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/reaction_game_pkg.sv
// -----------------------------------------------------------------------------
// reaction_game_pkg
// Widths and types shared by the reaction-game FSM and the reaction_timer, so
// both ends of the timer interface agree on the command/value widths.
//   TIMER_W      : width of the millisecond reaction count (timer_value)
//   GAME_TIMER_W : width of the elapsed game-seconds count (game_timer_value)
// -----------------------------------------------------------------------------
package reaction_game_pkg;

  localparam int TIMER_W      = 11;
  localparam int GAME_TIMER_W = 6;

  typedef logic [TIMER_W-1:0]      timer_t;
  typedef logic [GAME_TIMER_W-1:0] game_timer_t;

  // Reload value for a down-count: never start above the ceiling.
  function automatic timer_t clamp_load(input timer_t value, input timer_t ceiling);
    return (value > ceiling) ? ceiling : value;
  endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// -----------------------------------------------------------------------------
// ms_tick_gen
// Prescaler that divides the system clock down to a one-cycle tick every
// CLKS_PER_MS enabled cycles. The partial count is held while run is low.
//   clk   : system clock
//   rst_n : asynchronous active-low reset
//   clear : synchronous clear of the partial count (wins over run)
//   run   : advance the prescaler this cycle
//   tick  : high in the enabled cycle where the count sits at CLKS_PER_MS-1
// -----------------------------------------------------------------------------
module ms_tick_gen #(
  parameter int CLKS_PER_MS = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic run,
  output logic tick
);

  localparam int              CNT_W = (CLKS_PER_MS > 1) ? $clog2(CLKS_PER_MS) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLKS_PER_MS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             at_last;

  assign at_last = (cnt_q == LAST);

  // NOTE: every always_comb output gets a default on entry so no path leaves
  // it unassigned, which is what would otherwise infer a latch.
  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (run) begin
      cnt_d = at_last ? '0 : cnt_q + CNT_W'(1);
    end
  end

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge values regardless of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // A clear in the same cycle is resolved by the consumer's priority logic.
  assign tick = run && at_last;

endmodule

// File: rtl/reaction_timer.sv
// -----------------------------------------------------------------------------
// reaction_timer
// Millisecond timing engine for the reaction game: a saturating up/down ms
// counter with a terminal-count pulse, and a game-length seconds counter.
//   clk, rst_n        : clock, asynchronous active-low reset
//   reset             : reload ms counter (0 when up, else min(load_value,MAX_MS))
//   up                : count direction, 1 = up, 0 = down
//   enable            : ms counter and its prescaler run while high
//   load_value        : reload value for down-counting
//   timer_value       : current ms count (registered)
//   timer_done        : one-cycle pulse on counting onto the terminal value
//   game_reset        : clear game prescaler, ms sub-counter and seconds
//   game_timer_enable : game timer runs while high
//   game_timer_value  : elapsed game seconds, saturating at GAME_LEN_S
//   game_over         : high while game_timer_value == GAME_LEN_S
// -----------------------------------------------------------------------------
module reaction_timer
  import reaction_game_pkg::*;
#(
  parameter int CLKS_PER_MS = 50000,
  parameter int MAX_MS      = 2047,
  parameter int MS_PER_S    = 1000,
  parameter int GAME_LEN_S  = 60
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    reset,
  input  logic                    up,
  input  logic                    enable,
  input  logic [TIMER_W-1:0]      load_value,
  output logic [TIMER_W-1:0]      timer_value,
  output logic                    timer_done,
  input  logic                    game_reset,
  input  logic                    game_timer_enable,
  output logic [GAME_TIMER_W-1:0] game_timer_value,
  output logic                    game_over
);

  localparam timer_t      MAX_V      = timer_t'(MAX_MS);
  localparam game_timer_t GAME_LEN_V = game_timer_t'(GAME_LEN_S);
  localparam int          SUB_W      = (MS_PER_S > 1) ? $clog2(MS_PER_S) : 1;
  localparam logic [SUB_W-1:0] SUB_LAST = SUB_W'(MS_PER_S - 1);

  // ---------------------------------------------------------------------------
  // Reaction ms counter
  // ---------------------------------------------------------------------------
  logic   react_tick;
  timer_t timer_q, timer_d;
  logic   done_q, done_d;

  ms_tick_gen #(
    .CLKS_PER_MS(CLKS_PER_MS)
  ) u_react_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(reset),
    .run  (enable),
    .tick (react_tick)
  );

  // done_d is only raised on a counting step that lands on the terminal value,
  // so sitting at saturation or reloading to 0 never produces a pulse.
  always_comb begin
    timer_d = timer_q;
    done_d  = 1'b0;
    if (reset) begin
      timer_d = up ? '0 : clamp_load(load_value, MAX_V);
    end else if (enable && react_tick) begin
      if (up) begin
        if (timer_q < MAX_V) begin
          timer_d = timer_q + timer_t'(1);
          done_d  = (timer_d == MAX_V);
        end
      end else begin
        if (timer_q != '0) begin
          timer_d = timer_q - timer_t'(1);
          done_d  = (timer_d == '0);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      timer_q <= '0;
      done_q  <= 1'b0;
    end else begin
      timer_q <= timer_d;
      done_q  <= done_d;
    end
  end

  assign timer_value = timer_q;
  assign timer_done  = done_q;

  // ---------------------------------------------------------------------------
  // Game seconds counter
  // ---------------------------------------------------------------------------
  logic              game_tick;
  logic [SUB_W-1:0]  sub_q, sub_d;
  game_timer_t       sec_q, sec_d;

  ms_tick_gen #(
    .CLKS_PER_MS(CLKS_PER_MS)
  ) u_game_tick (
    .clk  (clk),
    .rst_n(rst_n),
    .clear(game_reset),
    .run  (game_timer_enable),
    .tick (game_tick)
  );

  always_comb begin
    sub_d = sub_q;
    sec_d = sec_q;
    if (game_reset) begin
      sub_d = '0;
      sec_d = '0;
    end else if (game_tick) begin
      if (sub_q == SUB_LAST) begin
        sub_d = '0;
        if (sec_q < GAME_LEN_V) begin
          sec_d = sec_q + game_timer_t'(1);
        end
      end else begin
        sub_d = sub_q + SUB_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sub_q <= '0;
      sec_q <= '0;
    end else begin
      sub_q <= sub_d;
      sec_q <= sec_d;
    end
  end

  assign game_timer_value = sec_q;
  assign game_over        = (sec_q == GAME_LEN_V);

endmodule

// File: tb/tb_reaction_timer.sv
// -----------------------------------------------------------------------------
// tb_reaction_timer
// Scoreboard bench for reaction_timer with CLKS_PER_MS=4, MS_PER_S=5,
// GAME_LEN_S=3, MAX_MS=2047. Stimulus drives inputs on the falling edge and
// queues hand-computed expected outputs; a monitor pops and compares them.
// -----------------------------------------------------------------------------
module tb_reaction_timer;
  import reaction_game_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        reset;
  logic        up;
  logic        enable;
  timer_t      load_value;
  timer_t      timer_value;
  logic        timer_done;
  logic        game_reset;
  logic        game_timer_enable;
  game_timer_t game_timer_value;
  logic        game_over;

  reaction_timer #(
    .CLKS_PER_MS(4),
    .MAX_MS     (2047),
    .MS_PER_S   (5),
    .GAME_LEN_S (3)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .reset            (reset),
    .up               (up),
    .enable           (enable),
    .load_value       (load_value),
    .timer_value      (timer_value),
    .timer_done       (timer_done),
    .game_reset       (game_reset),
    .game_timer_enable(game_timer_enable),
    .game_timer_value (game_timer_value),
    .game_over        (game_over)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       name;
    int          cyc;
    timer_t      tv;
    logic        done;
    game_timer_t gv;
    logic        over;
    logic [3:0]  mask;  // [0] tv, [1] done, [2] gv, [3] over
  } exp_t;

  exp_t exp_q[$];
  int   cyc_cnt = 0;
  int   checks  = 0;
  int   passed  = 0;
  event mon_ev;

  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  task automatic check(input exp_t e);
    bit ok;
    checks++;
    ok = (e.cyc == cyc_cnt);
    if (e.mask[0] && timer_value      !== e.tv)   ok = 1'b0;
    if (e.mask[1] && timer_done       !== e.done) ok = 1'b0;
    if (e.mask[2] && game_timer_value !== e.gv)   ok = 1'b0;
    if (e.mask[3] && game_over        !== e.over) ok = 1'b0;
    if (ok) begin
      passed++;
    end else begin
      $display("FAIL %s: got tv=%0d done=%0b gv=%0d over=%0b cyc=%0d, want tv=%0d done=%0b gv=%0d over=%0b cyc=%0d (mask %b)",
               e.name, timer_value, timer_done, game_timer_value, game_over, cyc_cnt,
               e.tv, e.done, e.gv, e.over, e.cyc, e.mask);
    end
  endtask

  // Monitor: compares queued expectations once outputs have settled.
  initial begin
    forever begin : mon_loop
      exp_t e;
      @(negedge clk or mon_ev);
      #1;
      while (exp_q.size() > 0 && exp_q[0].cyc <= cyc_cnt) begin
        e = exp_q.pop_front();
        check(e);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic push(input string name, input timer_t tv, input logic done,
                      input game_timer_t gv, input logic over, input logic [3:0] mask);
    exp_t e;
    e.name = name;
    e.cyc  = cyc_cnt;
    e.tv   = tv;
    e.done = done;
    e.gv   = gv;
    e.over = over;
    e.mask = mask;
    exp_q.push_back(e);
  endtask

  task automatic exp_tmr(input string name, input timer_t tv, input logic done);
    push(name, tv, done, '0, 1'b0, 4'b1111);
  endtask

  task automatic exp_game(input string name, input game_timer_t gv, input logic over);
    push(name, '0, 1'b0, gv, over, 4'b1100);
  endtask

  initial begin
    rst_n             = 1'b0;
    reset             = 1'b0;
    up                = 1'b0;
    enable            = 1'b0;
    load_value        = '0;
    game_reset        = 1'b0;
    game_timer_enable = 1'b0;

    step(2);
    exp_tmr("por_state", 11'd0, 1'b0);
    rst_n = 1'b1;

    // Up count from a reload, first change after four enabled cycles.
    step(1);
    reset = 1'b1; up = 1'b1;
    step(1);
    exp_tmr("up_reload", 11'd0, 1'b0);
    reset = 1'b0; enable = 1'b1;
    step(3);
    exp_tmr("up_latency_hold", 11'd0, 1'b0);
    step(1);
    exp_tmr("up_first_step", 11'd1, 1'b0);
    step(144);
    exp_tmr("up_at_37", 11'd37, 1'b0);

    // Asynchronous reset between clock edges.
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    exp_tmr("async_reset", 11'd0, 1'b0);
    -> mon_ev;
    @(negedge clk);
    rst_n = 1'b1; enable = 1'b0;

    // Down count 3,2,1,0 with a single done pulse.
    reset = 1'b1; up = 1'b0; load_value = 11'd3;
    step(1);
    exp_tmr("down_load", 11'd3, 1'b0);
    reset = 1'b0; enable = 1'b1;
    step(4);
    exp_tmr("down_2", 11'd2, 1'b0);
    step(4);
    exp_tmr("down_1", 11'd1, 1'b0);
    step(3);
    exp_tmr("down_1_hold", 11'd1, 1'b0);
    step(1);
    exp_tmr("down_0_done", 11'd0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      step(1);
      exp_tmr("down_sat_no_repulse", 11'd0, 1'b0);
    end

    // Up reload ignores load_value; reset beats enable.
    reset = 1'b1; up = 1'b1; load_value = 11'd5;
    step(1);
    exp_tmr("up_reload_ignores_load", 11'd0, 1'b0);
    reset = 1'b0;
    step(4);
    exp_tmr("up_step_again", 11'd1, 1'b0);

    // Saturation at MAX_MS: preload 2046 down, then flip direction.
    reset = 1'b1; up = 1'b0; load_value = 11'd2046;
    step(1);
    exp_tmr("preload_2046", 11'd2046, 1'b0);
    reset = 1'b0; up = 1'b1;
    step(3);
    exp_tmr("pre_sat_hold", 11'd2046, 1'b0);
    step(1);
    exp_tmr("sat_2047_done", 11'd2047, 1'b1);
    for (int i = 0; i < 12; i++) begin
      step(1);
      exp_tmr("up_sat_no_repulse", 11'd2047, 1'b0);
    end

    // Pause mid-ms keeps the partial prescaler count.
    reset = 1'b1; up = 1'b1;
    step(1);
    exp_tmr("pause_reload", 11'd0, 1'b0);
    reset = 1'b0;
    step(2);
    enable = 1'b0;
    step(10);
    exp_tmr("pause_hold", 11'd0, 1'b0);
    enable = 1'b1;
    step(1);
    exp_tmr("resume_partial", 11'd0, 1'b0);
    step(1);
    exp_tmr("resume_step", 11'd1, 1'b0);

    // Reload in the same cycle as a tick wins and clears the prescaler.
    step(3);
    exp_tmr("pre_tick", 11'd1, 1'b0);
    reset = 1'b1; up = 1'b0; load_value = 11'd100;
    step(1);
    exp_tmr("reset_beats_tick", 11'd100, 1'b0);
    reset = 1'b0;
    step(3);
    exp_tmr("reload_prescaler_cleared", 11'd100, 1'b0);
    step(1);
    exp_tmr("down_from_100", 11'd99, 1'b0);

    // Direction change mid-ms: no reload, prescaler phase kept.
    step(2);
    up = 1'b1;
    step(2);
    exp_tmr("dir_change_next_tick", 11'd100, 1'b0);

    // Game timer from clear: 1,2,3 at cycles 20,40,60 then saturate.
    enable = 1'b0;
    game_reset = 1'b1;
    step(1);
    exp_game("game_clear", 6'd0, 1'b0);
    game_reset = 1'b0; game_timer_enable = 1'b1;
    step(19);
    exp_game("game_pre_1", 6'd0, 1'b0);
    step(1);
    exp_game("game_1", 6'd1, 1'b0);
    step(20);
    exp_game("game_2", 6'd2, 1'b0);
    step(19);
    exp_game("game_pre_3", 6'd2, 1'b0);
    step(1);
    exp_game("game_3_over", 6'd3, 1'b1);
    step(100);
    exp_game("game_sat", 6'd3, 1'b1);

    // game_reset beats game_timer_enable and restarts a full second.
    game_reset = 1'b1;
    step(1);
    exp_game("game_reclear", 6'd0, 1'b0);
    game_reset = 1'b0;
    step(40);
    exp_game("game_back_to_2", 6'd2, 1'b0);
    step(7);
    game_reset = 1'b1;
    step(1);
    exp_game("game_reset_priority", 6'd0, 1'b0);
    game_reset = 1'b0;
    step(19);
    exp_game("game_full_second_hold", 6'd0, 1'b0);
    step(1);
    exp_game("game_full_second_1", 6'd1, 1'b0);

    step(2);
    while (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      checks++;
      $display("FAIL %s: never compared, queued for cyc=%0d, now cyc=%0d", e.name, e.cyc, cyc_cnt);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
